ethernet_tx_arbiter: RTL and testbench
======================================

ETHERNET_TX_ARBITER -- requirements
Module: ethernet_tx_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of AXI-Stream TX requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, per-port tdata width.
REQ-003 Parameter STALL_TIMEOUT, default 1024, idle cycles of the granted source mid-packet before the packet is aborted (>=2).
REQ-004 clk  input  1  single clock for all logic (MAC core clock domain).
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 s_tdata  input  NUM_PORTS*DATA_WIDTH  requester data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 s_tvalid / s_tuser / s_tlast  input  NUM_PORTS each  per-port valid, error flag, end-of-packet.
REQ-008 s_tready  output  NUM_PORTS  per-port ready.
REQ-009 m_tdata  output  DATA_WIDTH; m_tvalid, m_tuser, m_tlast  output  1 each  stream to the MAC TX FIFO.
REQ-010 m_tready  input  1  downstream ready.
REQ-011 grant  output  NUM_PORTS  one-hot owner of the output stream, zero when none.
REQ-012 abort_count  output  16  number of packets aborted by timeout, saturating.

Function
REQ-013 States: IDLE, PASS, ABORT, DRAIN.
- IDLE: grant=0, s_tready=0, m_tvalid=0.
- If any s_tvalid is high in IDLE, port = first set bit scanning last_grant+1, last_grant+2, ... modulo NUM_PORTS; register it as grant, next state PASS.
- Arbitration latency: exactly 1 cycle from s_tvalid seen in IDLE to grant asserted.
REQ-014 PASS behaviour:
- m_tdata/m_tvalid/m_tuser/m_tlast are combinational copies of the granted port.
- s_tready[g]=m_tready; all other s_tready=0.
- No data buffering, zero added latency.
REQ-015 PASS exit: on m_tvalid&m_tready&m_tlast, last_grant<=g, next state IDLE; the same port may not win again before every other valid port was offered once.
REQ-016 Packet lock: grant never changes in PASS until tlast handshake or abort, regardless of other requests.
REQ-017 Stall counter in PASS:
- Clears on every m_tvalid&m_tready handshake and on PASS entry.
- Increments each cycle s_tvalid[g]=0.
- Does not count while s_tvalid[g]=1 and m_tready=0 (downstream backpressure never aborts).
REQ-018 When the stall counter reaches STALL_TIMEOUT-1 with s_tvalid[g]=0, next state ABORT; abort_count increments, saturating at 16'hFFFF.
REQ-019 ABORT behaviour:
- Drives m_tvalid=1, m_tdata=0, m_tuser=1, m_tlast=1; s_tready=0 for all ports.
- On m_tready, next state DRAIN.
REQ-020 DRAIN: s_tready[g]=1, m_tvalid=0; beats of port g are discarded until a beat with s_tlast=1 is accepted, then last_grant<=g, next state IDLE.
REQ-021 A beat with s_tuser=1 in PASS is forwarded unchanged and does not end the packet.
REQ-022 Simultaneous timeout expiry and handshake in the same cycle: handshake wins, counter clears, no abort.
REQ-023 A single-beat packet (tlast on first beat) completes PASS in one handshake cycle.

Reset
REQ-024 On reset_n low, immediately:
- State IDLE, grant=0, s_tready=0, m_tvalid=0, m_tuser=0, m_tlast=0, m_tdata=0.
- Stall counter 0, abort_count 0, last_grant=NUM_PORTS-1 (port 0 wins first).
REQ-025 Reset asserted mid-packet truncates it with no abort beat; release is synchronised internally (2-flop) so the first state transition occurs no earlier than the second clk edge after reset_n rises.

Verification
REQ-026 Ports 0..3 each request a 3-beat packet simultaneously, m_tready=1 -> output order 0,1,2,3, 12 beats, grant one-hot each packet, 1 idle cycle between packets.
REQ-027 Port 2 sends a 64-byte packet while port 1 requests throughout -> port 2 packet is contiguous; grant moves to port 1 only after port 2 tlast handshake.
REQ-028 Port 0 stalls s_tvalid for STALL_TIMEOUT cycles after beat 5 -> m_tuser=1/m_tlast=1/m_tdata=0 beat emitted, abort_count=1, remaining port 0 beats up to tlast consumed with m_tvalid=0.
REQ-029 m_tready held low 5000 cycles mid-packet with s_tvalid high -> no abort, abort_count=0, packet resumes intact.
REQ-030 Only port 3 requests repeatedly, 5 single-beat packets -> each granted to port 3, one idle cycle each, grant=4'b1000.
REQ-031 reset_n pulsed low during beat 10 of a port 1 packet -> all outputs zero asynchronously, next arbitration starts at port 0.

Source files
------------

// File: rtl/ethernet_tx_arbiter.sv
// Round-robin arbiter merging NUM_PORTS AXI-Stream TX sources into one MAC stream.
// Packets are passed through without buffering. A packet whose source goes silent
// for STALL_TIMEOUT cycles is terminated with an error beat, and its tail is then drained.
module ethernet_tx_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    input  logic [NUM_PORTS-1:0]            s_tuser,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    output logic [NUM_PORTS-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic                            m_tvalid,
    output logic                            m_tuser,
    output logic                            m_tlast,
    input  logic                            m_tready,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [15:0]                     abort_count
);

    localparam int IW = $clog2(NUM_PORTS);
    localparam int SW = $clog2(STALL_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic [15:0]     abort_q, abort_d;
    logic [1:0]      sync_q;

    logic                  run_s;
    logic                  pick_found_s;
    logic [IW-1:0]         pick_idx_s;
    logic [DATA_WIDTH-1:0] port_data_s [NUM_PORTS];
    logic [NUM_PORTS-1:0]  gnt_onehot_s;
    logic                  g_valid_s;
    logic                  g_last_s;
    logic                  g_user_s;
    logic [DATA_WIDTH-1:0] g_data_s;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_split
        assign port_data_s[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign run_s        = sync_q[1];
    assign gnt_onehot_s = {{(NUM_PORTS-1){1'b0}}, 1'b1} << gnt_q;
    assign g_valid_s    = s_tvalid[gnt_q];
    assign g_last_s     = s_tlast[gnt_q];
    assign g_user_s     = s_tuser[gnt_q];
    assign g_data_s     = port_data_s[gnt_q];
    assign abort_count  = abort_q;

    // Reset release synchroniser: arbitration stays frozen until two edges after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    // Round-robin scan starting just after the previous owner.
    always_comb begin
        logic [IW-1:0] cand;
        cand         = '0;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = IW'((int'(last_q) + k) % NUM_PORTS);
            if (!pick_found_s && s_tvalid[cand]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state logic and stream muxing for each arbitration phase.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        stall_d  = stall_q;
        abort_d  = abort_q;
        grant    = '0;
        s_tready = '0;
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tuser  = 1'b0;
        m_tlast  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_s && pick_found_s) begin
                    state_d = ST_PASS;
                    gnt_d   = pick_idx_s;
                    stall_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PASS: begin
                grant    = gnt_onehot_s;
                s_tready = m_tready ? gnt_onehot_s : '0;
                m_tvalid = g_valid_s;
                m_tdata  = g_data_s;
                m_tuser  = g_user_s;
                m_tlast  = g_last_s;
                if (g_valid_s && m_tready) begin
                    // A handshake always resets the stall window, even on the timeout cycle.
                    stall_d = '0;
                    if (g_last_s) begin
                        state_d = ST_IDLE;
                        last_d  = gnt_q;
                    end else begin
                        state_d = ST_PASS;
                    end
                end else if (!g_valid_s) begin
                    if (stall_q == SW'(STALL_TIMEOUT - 1)) begin
                        state_d = ST_ABORT;
                        stall_d = '0;
                        abort_d = (abort_q != 16'hFFFF) ? abort_q + 16'd1 : abort_q;
                    end else begin
                        stall_d = stall_q + SW'(1);
                    end
                end else begin
                    // Downstream backpressure: hold the stall count.
                    stall_d = stall_q;
                end
            end
            ST_ABORT: begin
                grant    = gnt_onehot_s;
                m_tvalid = 1'b1;
                m_tuser  = 1'b1;
                m_tlast  = 1'b1;
                if (m_tready) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ABORT;
                end
            end
            ST_DRAIN: begin
                grant    = gnt_onehot_s;
                s_tready = gnt_onehot_s;
                if (g_valid_s && g_last_s) begin
                    state_d = ST_IDLE;
                    last_d  = gnt_q;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers; last owner resets to the top port so port 0 wins first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NUM_PORTS - 1);
            stall_q <= '0;
            abort_q <= 16'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            stall_q <= stall_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
// Bench for ethernet_tx_arbiter: randomized AXI-Stream sources, a packet-level reference
// model compared every cycle, and directed scenarios with hand-computed expectations.
module tb_ethernet_tx_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int TO = 8;

    localparam int M_IDLE  = 0;
    localparam int M_PASS  = 1;
    localparam int M_ABORT = 2;
    localparam int M_DRAIN = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NP*DW-1:0] s_tdata;
    logic [NP-1:0]    s_tvalid, s_tuser, s_tlast, s_tready;
    logic [DW-1:0]    m_tdata;
    logic             m_tvalid, m_tuser, m_tlast, m_tready;
    logic [NP-1:0]    grant;
    logic [15:0]      abort_count;

    ethernet_tx_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .STALL_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tuser(s_tuser), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .m_tready(m_tready),
        .grant(grant), .abort_count(abort_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Source packet queues: word = {stall_before[31:16], 6'b0, user, last, data[7:0]}
    logic [31:0] pq [NP][$];
    bit          loaded [NP];
    int          stall_left [NP];
    bit          hs_prev [NP];
    int          gap_pct = 0;
    int          mr_pct = 100;
    int          mr_low_left = 0;

    // Reference model state
    bit model_en = 1'b0;
    int m_mode, m_owner, m_last, m_idle, m_aborts;

    int          out_hs = 0;
    int          abort_hs = 0;
    logic [3:0]  glog [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_bit(input logic [NP-1:0] v, input int i);
        return 1'((v >> i) & NP'(1));
    endfunction

    function automatic logic [NP-1:0] put_bit(input logic [NP-1:0] v, input int i, input logic b);
        return (v & ~(NP'(1) << i)) | (NP'(b) << i);
    endfunction

    function automatic logic [31:0] mk(input int stall, input logic user, input logic last, input logic [7:0] d);
        return {16'(stall), 6'd0, user, last, d};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_owner = 0; m_last = NP - 1; m_idle = 0; m_aborts = 0;
    endtask

    task automatic drive_inputs();
        logic [31:0] w;
        for (int p = 0; p < NP; p++) begin
            bit vld;
            vld = 1'b0;
            if (hs_prev[p]) begin
                if (pq[p].size() > 0) w = pq[p].pop_front();
                loaded[p] = 1'b0;
            end
            if (get_bit(s_tvalid, p) && !hs_prev[p]) continue;
            if (pq[p].size() > 0) begin
                w = pq[p][0];
                if (!loaded[p]) begin
                    stall_left[p] = int'(w[31:16]);
                    loaded[p] = 1'b1;
                end
                if (stall_left[p] > 0) stall_left[p]--;
                else if ($urandom_range(99) >= gap_pct) vld = 1'b1;
            end
            if (!vld) w = {22'd0, 1'($urandom), 1'($urandom), 8'($urandom)};
            s_tvalid = put_bit(s_tvalid, p, vld);
            s_tlast  = put_bit(s_tlast, p, w[8]);
            s_tuser  = put_bit(s_tuser, p, w[9]);
            s_tdata  = (s_tdata & ~(32'hFF << (p*DW))) | (32'(w[7:0]) << (p*DW));
        end
        if (mr_low_left > 0) begin
            m_tready = 1'b0;
            mr_low_left--;
        end else begin
            m_tready = ($urandom_range(99) < mr_pct);
        end
    endtask

    task automatic check_cycle();
        logic [3:0] eg, esr;
        logic       ev, eu, el;
        logic [7:0] ed;
        int         o;
        glog.push_back(grant);
        if (m_tvalid && m_tready) begin
            out_hs++;
            if (m_tuser && m_tlast && m_tdata == 8'h00) abort_hs++;
        end
        if (model_en) begin
            eg = 4'd0; esr = 4'd0; ev = 1'b0; eu = 1'b0; el = 1'b0; ed = 8'd0;
            o = m_owner;
            case (m_mode)
                M_PASS: begin
                    eg = 4'(1 << o); esr = m_tready ? eg : 4'd0;
                    ev = get_bit(s_tvalid, o); eu = get_bit(s_tuser, o); el = get_bit(s_tlast, o);
                    ed = 8'(s_tdata >> (o*DW));
                end
                M_ABORT: begin eg = 4'(1 << o); ev = 1'b1; eu = 1'b1; el = 1'b1; end
                M_DRAIN: begin eg = 4'(1 << o); esr = eg; end
                default: ;
            endcase
            chk("grant", grant, eg);
            chk("s_tready", s_tready, esr);
            chk("m_tvalid", m_tvalid, ev);
            if (m_mode == M_PASS || m_mode == M_ABORT) begin
                chk("m_tdata", m_tdata, ed);
                chk("m_tuser", m_tuser, eu);
                chk("m_tlast", m_tlast, el);
            end
            chk("abort_count", abort_count, m_aborts);
            // Advance the model across the coming clock edge.
            case (m_mode)
                M_IDLE: begin
                    for (int k = 1; k <= NP; k++) begin
                        int c;
                        c = (m_last + k) % NP;
                        if (m_mode == M_IDLE && get_bit(s_tvalid, c)) begin
                            m_mode = M_PASS; m_owner = c; m_idle = 0;
                        end
                    end
                end
                M_PASS: begin
                    if (get_bit(s_tvalid, o) && m_tready) begin
                        m_idle = 0;
                        if (get_bit(s_tlast, o)) begin m_mode = M_IDLE; m_last = o; end
                    end else if (!get_bit(s_tvalid, o)) begin
                        m_idle++;
                        if (m_idle == TO) begin
                            m_mode = M_ABORT; m_idle = 0;
                            if (m_aborts < 65535) m_aborts++;
                        end
                    end
                end
                M_ABORT: if (m_tready) m_mode = M_DRAIN;
                M_DRAIN: if (get_bit(s_tvalid, o) && get_bit(s_tlast, o)) begin m_mode = M_IDLE; m_last = o; end
                default: ;
            endcase
        end
        for (int p = 0; p < NP; p++) hs_prev[p] = get_bit(s_tvalid, p) & get_bit(s_tready, p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_inputs();
        @(negedge clk);
        check_cycle();
    endtask

    function automatic bit queues_empty();
        for (int p = 0; p < NP; p++) if (pq[p].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_until_drained(input int max_cyc, input string name);
        int n;
        n = 0;
        while ((!queues_empty() || m_mode != M_IDLE) && n < max_cyc) begin
            step();
            n++;
        end
        chk({name, "_drained"}, 32'(n < max_cyc), 32'd1);
        repeat (2) step();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_grant"}, grant, 4'd0);
        chk({tag, "_s_tready"}, s_tready, 4'd0);
        chk({tag, "_m_tvalid"}, m_tvalid, 1'b0);
        chk({tag, "_m_tuser"}, m_tuser, 1'b0);
        chk({tag, "_m_tlast"}, m_tlast, 1'b0);
        chk({tag, "_m_tdata"}, m_tdata, 8'd0);
        chk({tag, "_abort_count"}, abort_count, 16'd0);
    endtask

    initial begin
        int base, base_ab, n, f2, l2, n2, nx, early1;
        reset_n = 1'b0;
        s_tvalid = '0; s_tdata = '0; s_tuser = '0; s_tlast = '0; m_tready = 1'b0;
        for (int p = 0; p < NP; p++) begin loaded[p] = 1'b0; stall_left[p] = 0; hs_prev[p] = 1'b0; end
        model_reset();
        #3;
        check_outputs_zero("rst");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        model_en = 1'b1;
        repeat (4) step();

        // Four simultaneous 3-beat packets: order 0,1,2,3 with one idle cycle between.
        gap_pct = 0; mr_pct = 100;
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < 3; b++) pq[p].push_back(mk(0, 1'b0, b == 2, 8'(16*p + b + 1)));
        base = out_hs; glog.delete();
        repeat (17) step();
        for (int i = 0; i < 17; i++) chk("t026_grant_seq", glog[i], (i % 4 == 0) ? 4'd0 : 4'(1 << (i / 4)));
        chk("t026_beats", out_hs - base, 12);

        // Port 3 alone, five single-beat packets.
        for (int k = 0; k < 5; k++) pq[3].push_back(mk(0, 1'b0, 1'b1, 8'(8'hA0 + k)));
        base = out_hs; glog.delete();
        repeat (10) step();
        for (int i = 0; i < 10; i++) chk("t030_grant_seq", glog[i], (i % 2 == 0) ? 4'd0 : 4'b1000);
        chk("t030_beats", out_hs - base, 5);

        // Port 2 sends 64 beats while port 1 requests throughout.
        for (int b = 0; b < 64; b++) pq[2].push_back(mk(0, 1'b0, b == 63, 8'(b + 1)));
        pq[1].push_back(mk(2, 1'b0, 1'b0, 8'h77));
        pq[1].push_back(mk(0, 1'b0, 1'b1, 8'h78));
        glog.delete();
        run_until_drained(300, "t027");
        f2 = -1; l2 = -1; n2 = 0; nx = 0; early1 = 0;
        for (int i = 0; i < glog.size(); i++) begin
            if (glog[i] == 4'b0100) begin n2++; if (f2 < 0) f2 = i; l2 = i; end
            if (glog[i] == 4'b0010 && f2 < 0) early1++;
        end
        for (int i = glog.size() - 1; i > l2 && l2 >= 0; i--) if (glog[i] != 4'd0) nx = int'(glog[i]);
        chk("t027_p2_cycles", n2, 64);
        chk("t027_p2_contig", l2 - f2 + 1, 64);
        chk("t027_p1_before", early1, 0);
        chk("t027_next_grant", nx, 4'b0010);

        // Port 0 goes silent for exactly STALL_TIMEOUT cycles after beat 5.
        for (int b = 0; b < 10; b++) pq[0].push_back(mk((b == 5) ? TO : 0, 1'b0, b == 9, 8'(8'h40 + b + 1)));
        base = out_hs; base_ab = abort_hs;
        run_until_drained(300, "t028");
        chk("t028_abort_count", abort_count, 16'd1);
        chk("t028_out_beats", out_hs - base, 6);
        chk("t028_abort_beats", abort_hs - base_ab, 1);

        // One cycle short of the timeout: no abort.
        for (int b = 0; b < 4; b++) pq[1].push_back(mk((b == 2) ? TO - 1 : 0, b == 1, b == 3, 8'(8'h50 + b + 1)));
        base = out_hs; base_ab = abort_hs;
        run_until_drained(300, "t028b");
        chk("t028b_abort_count", abort_count, 16'd1);
        chk("t028b_out_beats", out_hs - base, 4);
        chk("t028b_abort_beats", abort_hs - base_ab, 0);

        // Long downstream backpressure mid-packet never aborts.
        for (int b = 0; b < 6; b++) pq[3].push_back(mk(0, 1'b0, b == 5, 8'(8'h60 + b + 1)));
        base = out_hs; n = 0;
        while (out_hs - base < 2 && n < 50) begin step(); n++; end
        mr_low_left = 5000;
        run_until_drained(5100, "t029");
        chk("t029_abort_count", abort_count, 16'd1);
        chk("t029_out_beats", out_hs - base, 6);

        // Randomized traffic against the model.
        gap_pct = 25; mr_pct = 75;
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 8; k++) begin
                int len;
                len = int'($urandom_range(6, 1));
                for (int b = 0; b < len; b++) begin
                    int r, st;
                    r = int'($urandom_range(99));
                    st = (r < 70) ? 0 : (r < 85) ? int'($urandom_range(3, 1)) :
                         (r < 92) ? TO - 1 : TO + int'($urandom_range(3));
                    pq[p].push_back(mk(st, $urandom_range(9) == 0, b == len - 1, 8'($urandom)));
                end
            end
        run_until_drained(20000, "rand");

        // Reset during beat 10 of a port 1 packet.
        gap_pct = 0; mr_pct = 100;
        for (int b = 0; b < 16; b++) pq[1].push_back(mk(0, 1'b0, b == 15, 8'(b + 1)));
        base = out_hs; n = 0;
        while (out_hs - base < 10 && n < 100) begin step(); n++; end
        chk("t031_reach_beat10", out_hs - base, 10);
        #2 reset_n = 1'b0;
        model_en = 1'b0;
        #1;
        check_outputs_zero("t031_async");
        for (int p = 0; p < NP; p++) begin
            pq[p].delete(); loaded[p] = 1'b0; stall_left[p] = 0; hs_prev[p] = 1'b0;
            pq[p].push_back(mk(0, 1'b0, 1'b1, 8'(8'hC0 + p)));
        end
        s_tvalid = '0;
        repeat (2) step();
        #2 reset_n = 1'b1;
        step();
        chk("t031_sync_hold", grant, 4'd0);
        n = 0;
        while (grant == 4'd0 && n < 5) begin step(); n++; end
        chk("t031_first_grant", grant, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
